inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Responder end of the instruction-fetch interface (ce / addr / inst) used by the CPU core in the minimal SOPC.
- Synchronous instruction RAM with a byte-stream program-load port.
- Holds the CPU in stall while a program image is streamed in, then serves fetches with one-cycle registered latency.
- Replaces the combinational ROM when programs are loaded at run time instead of at elaboration.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words).
- NOP_WORD, 32'h00000013, word returned for out-of-range fetches (RISC-V addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  fetch enable from CPU
- addr  in  32  fetch byte address
- inst  out  32  fetched instruction, registered
- inst_valid  out  1  inst holds data for the fetch issued the previous cycle
- cpu_stall_o  out  1  high while not in RUN
- load_start_i  in  1  one-cycle request to begin a program load
- ld_valid_i  in  1  load byte valid
- ld_byte_i  in  8  load byte, little-endian within each word
- ld_last_i  in  1  qualifies the final byte of the image
- ld_ready_o  out  1  load byte accepted when ld_valid_i & ld_ready_o
- load_done_o  out  1  one-cycle pulse when a load completes
- load_words_o  out  DEPTH_LOG2+1  number of words written by the last or current load
- load_err_o  out  1  sticky; image exceeded capacity
- load_sum_o  out  32  load checksum (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - FSM state IDLE; inst = 0; inst_valid = 0; cpu_stall_o = 1.
  - ld_ready_o = 0; load_done_o = 0; load_words_o = 0; load_err_o = 0; load_sum_o = 0.
  - Byte lane counter and word pointer = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, FLUSH, RUN.
  - IDLE: stall = 1; ld_ready_o = 0. load_start_i -> LOAD.
  - LOAD: ld_ready_o = 1.
    - On each accepted byte, place it in lane[1:0] of an assembly register (lane 0 = bits 7:0) and increment the lane.
    - On lane 3, or on ld_last_i, write the assembled word to mem[word_ptr] and increment word_ptr and load_words_o.
    - Unfilled lanes of a partial last word are written as 0.
    - Accepted ld_last_i -> FLUSH.
  - FLUSH: one cycle; ld_ready_o = 0; load_done_o = 1; clears lane, word_ptr and the assembly register -> RUN.
  - RUN: stall = 0. load_start_i -> LOAD (reload): word_ptr and load_words_o reset to 0, load_err_o cleared, stall high from the next cycle.
- Capacity: once word_ptr = 2^DEPTH_LOG2, further words are accepted and discarded. load_err_o is set, and load_words_o saturates at 2^DEPTH_LOG2.
- Ignored inputs:
  - load_start_i in LOAD or FLUSH is ignored.
  - ld_valid_i outside LOAD is ignored.
- Fetch (RUN only), one-cycle latency:
  - ce = 1 at edge N -> at edge N+1, inst = mem[addr[DEPTH_LOG2+1:2]] and inst_valid = 1.
  - addr[1:0] is ignored.
  - If addr[31:DEPTH_LOG2+2] != 0, inst = NOP_WORD with inst_valid = 1.
  - ce = 0 -> inst = 0, inst_valid = 0.
- Fetch outside RUN: inst = 0 and inst_valid = 0 regardless of ce.
- Reset mid-load: returns to IDLE; a partially assembled word is lost; memory written so far is retained; load_words_o = 0.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined:
  - load_sum_o accumulates the 32-bit wrap-around sum of every word written during LOAD, including a zero-padded last word. Discarded overflow words are excluded.
  - The sum is cleared on load start and held after FLUSH.
- Undefined: load_sum_o tied to 0; no adder is synthesised.

Test Plan:
- Reset, then load_start_i, then bytes 13 00 00 00 93 00 10 00 with ld_last on byte 8 -> mem[0]=0x00000013, mem[1]=0x00100093; load_done pulse; load_words_o=2; stall drops the cycle after FLUSH.
- In RUN, ce=1 with addr=0x4 -> next cycle inst=0x00100093, inst_valid=1; ce=1 with addr=0x00001000 (DEPTH_LOG2=10) -> inst=0x00000013.
- 5-byte image AA BB CC DD EE with last on EE -> mem[1]=0x000000EE, load_words_o=2; with LOAD_CHECKSUM_EN, load_sum_o=0xDDCCBBAA+0xEE=0xDDCCBC98.
- DEPTH_LOG2=2, 20-byte image -> load_words_o=4, load_err_o=1, mem[0..3] hold the first 16 bytes.
- rst asserted after 6 bytes of a load -> IDLE, stall=1, load_words_o=0, mem[0] retains the first word; ce=1 -> inst_valid stays 0.
- In RUN, load_start_i together with ce=1 -> no inst_valid on the following cycle; stall=1; reload proceeds from word 0.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction RAM with a byte-stream program loader and one-cycle fetch port.
// Optional checksum of loaded words is enabled by defining LOAD_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  cpu_stall_o,
  input  logic                  load_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  load_done_o,
  output logic [DEPTH_LOG2:0]   load_words_o,
  output logic                  load_err_o,
  output logic [31:0]           load_sum_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]           mem [DEPTH];
  logic [1:0]            lane;
  logic [DEPTH_LOG2:0]   word_ptr;
  logic [31:0]           asm_word;
  logic [31:0]           word;
  logic                  accept;
  logic                  wr_word;
  logic                  room;
  logic                  start;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] rd_idx;

  always_comb begin
    accept   = (state == LOAD) && ld_valid_i;
    wr_word  = accept && ((lane == 2'd3) || ld_last_i);
    room     = !word_ptr[DEPTH_LOG2];
    start    = load_start_i && ((state == IDLE) || (state == RUN));
    // Upper lanes of asm_word are always zero, so a short last word pads itself.
    word     = asm_word | ({24'b0, ld_byte_i} << {lane, 3'b000});
    rd_idx   = addr[DEPTH_LOG2+1:2];
    in_range = (addr >> (DEPTH_LOG2 + 2)) == 32'd0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (load_start_i) state_nx = LOAD;
      LOAD:  if (accept && ld_last_i) state_nx = FLUSH;
      FLUSH: state_nx = RUN;
      RUN:   if (load_start_i) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      inst         <= '0;
      inst_valid   <= 1'b0;
      cpu_stall_o  <= 1'b1;
      ld_ready_o   <= 1'b0;
      load_done_o  <= 1'b0;
      load_words_o <= '0;
      load_err_o   <= 1'b0;
      lane         <= '0;
      word_ptr     <= '0;
      asm_word     <= '0;
    end else begin
      state       <= state_nx;
      cpu_stall_o <= state_nx != RUN;
      ld_ready_o  <= state_nx == LOAD;
      load_done_o <= state_nx == FLUSH;
      inst        <= '0;
      inst_valid  <= 1'b0;
      // A reload request wins over a same-cycle fetch.
      if ((state == RUN) && !load_start_i && ce) begin
        inst_valid <= 1'b1;
        inst       <= in_range ? mem[rd_idx] : NOP_WORD;
      end
      if (start) begin
        word_ptr     <= '0;
        load_words_o <= '0;
        load_err_o   <= 1'b0;
        lane         <= '0;
        asm_word     <= '0;
      end
      if (accept) begin
        lane     <= lane + 2'd1;
        asm_word <= word;
      end
      if (wr_word) begin
        lane     <= '0;
        asm_word <= '0;
        if (room) begin
          word_ptr     <= word_ptr + 1'b1;
          load_words_o <= word_ptr + 1'b1;
        end else begin
          load_err_o <= 1'b1;
        end
      end
      if (state == FLUSH) begin
        lane     <= '0;
        word_ptr <= '0;
        asm_word <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_word && room)
      mem[word_ptr[DEPTH_LOG2-1:0]] <= word;
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      load_sum_o <= '0;
    else if (start)
      load_sum_o <= '0;
    else if (wr_word && room)
      load_sum_o <= load_sum_o + word;
  end
`else
  assign load_sum_o = '0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: default depth and a 4-word instance.
// Fetches go through a scoreboard queue; status outputs are checked directly.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        load_start;
  logic        load_start_s;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;

  logic [31:0] inst, inst_s;
  logic        iv, iv_s;
  logic        stall, stall_s;
  logic        rdy, rdy_s;
  logic        done, done_s;
  logic [10:0] words;
  logic [2:0]  words_s;
  logic        err, err_s;
  logic [31:0] sum, sum_s;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LOAD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  always #5 clk = ~clk;

  inst_mem_loader u_dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst), .inst_valid(iv), .cpu_stall_o(stall),
    .load_start_i(load_start), .ld_valid_i(ld_valid),
    .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(rdy), .load_done_o(done),
    .load_words_o(words), .load_err_o(err), .load_sum_o(sum)
  );

  inst_mem_loader #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst_s), .inst_valid(iv_s), .cpu_stall_o(stall_s),
    .load_start_i(load_start_s), .ld_valid_i(ld_valid),
    .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(rdy_s), .load_done_o(done_s),
    .load_words_o(words_s), .load_err_o(err_s), .load_sum_o(sum_s)
  );

  typedef struct {
    logic        sel;
    logic        ce_v;
    logic [31:0] a;
    logic        ev;
    logic [31:0] ei;
  } vec_t;

  typedef struct {
    logic        sel;
    logic        v;
    logic [31:0] i;
  } exp_t;

  exp_t q[$];

  function automatic logic [31:0] ck(input logic [31:0] x);
    return CK ? x : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input vec_t v);
    exp_t e;
    ce   = v.ce_v;
    addr = v.a;
    q.push_back('{v.sel, v.ev, v.ei});
    tick();
    ce = 1'b0;
    e  = q.pop_front();
    if (e.sel) begin
      chk("fetch_valid_s", {31'b0, iv_s}, {31'b0, e.v});
      chk("fetch_inst_s", inst_s, e.i);
    end else begin
      chk("fetch_valid", {31'b0, iv}, {31'b0, e.v});
      chk("fetch_inst", inst, e.i);
    end
  endtask

  vec_t t1[7];
  vec_t t2[2];
  vec_t t3[6];
  vec_t t4[3];
  logic [7:0] p1[8];
  logic [7:0] p2[5];

  initial begin
    p1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    p2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    t1[0] = '{1'b0, 1'b1, 32'h4,        1'b1, 32'h00100093};
    t1[1] = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h00000013};
    t1[2] = '{1'b0, 1'b1, 32'h00001000, 1'b1, 32'h00000013};
    t1[3] = '{1'b0, 1'b1, 32'h80000004, 1'b1, 32'h00000013};
    t1[4] = '{1'b0, 1'b1, 32'h7,        1'b1, 32'h00100093};
    t1[5] = '{1'b0, 1'b0, 32'h4,        1'b0, 32'h0};
    t1[6] = '{1'b0, 1'b1, 32'h5,        1'b1, 32'h00100093};
    t2[0] = '{1'b0, 1'b1, 32'h4,        1'b1, 32'h000000EE};
    t2[1] = '{1'b0, 1'b1, 32'h0,        1'b1, 32'hDDCCBBAA};
    t3[0] = '{1'b1, 1'b1, 32'h0,        1'b1, 32'h13121110};
    t3[1] = '{1'b1, 1'b1, 32'h4,        1'b1, 32'h17161514};
    t3[2] = '{1'b1, 1'b1, 32'h8,        1'b1, 32'h1B1A1918};
    t3[3] = '{1'b1, 1'b1, 32'hC,        1'b1, 32'h1F1E1D1C};
    t3[4] = '{1'b1, 1'b1, 32'h10,       1'b1, 32'h00000013};
    t3[5] = '{1'b1, 1'b1, 32'h3,        1'b1, 32'h13121110};
    t4[0] = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h04030201};
    t4[1] = '{1'b0, 1'b1, 32'h4,        1'b1, 32'h000000EE};
    t4[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

    rst = 1'b1; ce = 1'b0; addr = '0;
    load_start = 1'b0; load_start_s = 1'b0;
    ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    tick();
    ce = 1'b1;
    tick();
    rst = 1'b0;
    ce  = 1'b0;

    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, iv}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h1);
    chk("rst_ready", {31'b0, rdy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_words", 32'(words), 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_stall_s", {31'b0, stall_s}, 32'h1);

    // IDLE ignores load bytes and fetches
    send_byte(8'h55, 1'b1);
    chk("idle_ready", {31'b0, rdy}, 32'h0);
    chk("idle_words", 32'(words), 32'h0);
    fetch('{1'b0, 1'b1, 32'h0, 1'b0, 32'h0});

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ld_ready", {31'b0, rdy}, 32'h1);
    chk("ld_stall", {31'b0, stall}, 32'h1);
    for (int i = 0; i < 8; i++)
      send_byte(p1[i], i == 7);
    chk("p1_done", {31'b0, done}, 32'h1);
    chk("p1_words", 32'(words), 32'd2);
    chk("p1_ready", {31'b0, rdy}, 32'h0);
    chk("p1_flush_stall", {31'b0, stall}, 32'h1);
    chk("p1_sum", sum, ck(32'h00100093 + 32'h00000013));
    tick();
    chk("p1_run_stall", {31'b0, stall}, 32'h0);
    chk("p1_done_pulse", {31'b0, done}, 32'h0);
    chk("p1_words_hold", 32'(words), 32'd2);

    for (int i = 0; i < 7; i++)
      fetch(t1[i]);

    // reload request collides with a fetch
    load_start = 1'b1;
    fetch('{1'b0, 1'b1, 32'h4, 1'b0, 32'h0});
    load_start = 1'b0;
    chk("rl_stall", {31'b0, stall}, 32'h1);
    chk("rl_ready", {31'b0, rdy}, 32'h1);
    chk("rl_words", 32'(words), 32'h0);
    chk("rl_sum", sum, 32'h0);
    for (int i = 0; i < 5; i++)
      send_byte(p2[i], i == 4);
    chk("p2_done", {31'b0, done}, 32'h1);
    chk("p2_words", 32'(words), 32'd2);
    chk("p2_sum", sum, ck(32'hDDCCBC98));
    tick();
    for (int i = 0; i < 2; i++)
      fetch(t2[i]);

    // 20-byte image into the 4-word instance
    load_start_s = 1'b1;
    tick();
    load_start_s = 1'b0;
    chk("sm_ready", {31'b0, rdy_s}, 32'h1);
    for (int i = 0; i < 20; i++)
      send_byte(8'(8'h10 + i), i == 19);
    chk("sm_done", {31'b0, done_s}, 32'h1);
    chk("sm_words", 32'(words_s), 32'd4);
    chk("sm_err", {31'b0, err_s}, 32'h1);
    chk("sm_sum", sum_s, ck(32'h64605C58));
    chk("sm_dflt_words", 32'(words), 32'd2);
    tick();
    chk("sm_stall", {31'b0, stall_s}, 32'h0);
    for (int i = 0; i < 6; i++)
      fetch(t3[i]);

    // reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++)
      send_byte(8'(8'h11 * (i + 1)), 1'b0);
    chk("mid_words", 32'(words), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_stall", {31'b0, stall}, 32'h1);
    chk("mr_words", 32'(words), 32'h0);
    chk("mr_ready", {31'b0, rdy}, 32'h0);
    chk("mr_err_s", {31'b0, err_s}, 32'h0);
    fetch('{1'b0, 1'b1, 32'h0, 1'b0, 32'h0});

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h01, 1'b0);
    load_start = 1'b1;
    send_byte(8'h02, 1'b0);
    load_start = 1'b0;
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    chk("p3_done", {31'b0, done}, 32'h1);
    chk("p3_words", 32'(words), 32'd1);
    chk("p3_sum", sum, ck(32'h04030201));
    tick();
    for (int i = 0; i < 3; i++)
      fetch(t4[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
